// File: rtl/req_unique_arbiter.sv
// ---------------------------------------------------------------------------
// req_unique_arbiter : N-way single-owner arbiter with priority/RR/unique/unique0 modes
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module req_unique_arbiter #(
   parameter int N       = 4,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 arb_en,
   input  logic [N-1:0]         req,
   input  logic [1:0]           mode,
   input  logic                 done,
   output logic [N-1:0]         gnt,
   output logic                 gnt_valid,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 busy,
   output logic                 multi_err,
   output logic                 none_err,
   output logic                 timeout_err,
   output logic [CNT_W-1:0]     err_cnt
);

   localparam int ID_W = $clog2(N);
   localparam int TW   = $clog2(TIMEOUT);

   localparam logic [1:0] MODE_PRIO    = 2'b00;
   localparam logic [1:0] MODE_RR      = 2'b01;
   localparam logic [1:0] MODE_UNIQUE  = 2'b10;
   localparam logic [1:0] MODE_UNIQUE0 = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      COOL  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [N-1:0]      gnt_q, gnt_d;
   logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
   logic              multi_q, multi_d;
   logic              none_q, none_d;
   logic              tmo_err_q, tmo_err_d;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

   logic              w_lo_found, w_lo_multi;
   logic [ID_W-1:0]   w_lo_idx;
   logic              w_rr_found;
   logic [ID_W-1:0]   w_rr_idx;
   logic [ID_W:0]     w_rr_pos;
   logic              w_win_vld;
   logic [ID_W-1:0]   w_win_idx;

   // Lowest-index requester, plus a flag for more than one request
   always_comb begin
      w_lo_found = 1'b0;
      w_lo_multi = 1'b0;
      w_lo_idx   = '0;
      for (int i = 0; i < N; i++) begin
         if (req[i]) begin
            if (w_lo_found) begin
               w_lo_multi = 1'b1;
            end else begin
               w_lo_found = 1'b1;
               w_lo_idx   = ID_W'(i);
            end
         end
      end
   end

   // First requester at or after the round-robin pointer, wrapping past N-1
   always_comb begin
      w_rr_found = 1'b0;
      w_rr_idx   = '0;
      w_rr_pos   = '0;
      for (int k = 0; k < N; k++) begin
         w_rr_pos = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         if (w_rr_pos >= (ID_W+1)'(N)) begin
            w_rr_pos = w_rr_pos - (ID_W+1)'(N);
         end
         if (!w_rr_found && req[w_rr_pos[ID_W-1:0]]) begin
            w_rr_found = 1'b1;
            w_rr_idx   = w_rr_pos[ID_W-1:0];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      rr_ptr_d  = rr_ptr_q;
      tmo_cnt_d = tmo_cnt_q;
      multi_d   = 1'b0;
      none_d    = 1'b0;
      tmo_err_d = 1'b0;
      err_cnt_d = err_cnt_q;
      w_win_vld = 1'b0;
      w_win_idx = '0;

      case (state_q)
         IDLE: begin
            if (arb_en) begin
               case (mode)
                  MODE_PRIO: begin
                     w_win_vld = w_lo_found;
                     w_win_idx = w_lo_idx;
                  end
                  MODE_RR: begin
                     w_win_vld = w_rr_found;
                     w_win_idx = w_rr_idx;
                     if (w_rr_found) begin
                        rr_ptr_d = (w_rr_idx == ID_W'(N-1)) ? '0 : w_rr_idx + ID_W'(1);
                     end
                  end
                  MODE_UNIQUE: begin
                     w_win_vld = w_lo_found && !w_lo_multi;
                     w_win_idx = w_lo_idx;
                     multi_d   = w_lo_multi;
                     none_d    = !w_lo_found;
                  end
                  default: begin
                     w_win_vld = w_lo_found && !w_lo_multi;
                     w_win_idx = w_lo_idx;
                     multi_d   = w_lo_multi;
                  end
               endcase
               if (w_win_vld) begin
                  state_d            = GRANT;
                  gnt_d              = '0;
                  gnt_d[w_win_idx]   = 1'b1;
                  gnt_id_d           = w_win_idx;
                  tmo_cnt_d          = '0;
               end
            end
         end
         GRANT: begin
            if (done || (tmo_cnt_q == TW'(TIMEOUT-1))) begin
               state_d   = COOL;
               gnt_d     = '0;
               gnt_id_d  = '0;
               tmo_err_d = !done;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
         end
         COOL: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
         end
      endcase

      // Counter moves together with the pulse it counts
      if ((multi_d || none_d || tmo_err_d) && (err_cnt_q != {CNT_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         gnt_id_q  <= '0;
         rr_ptr_q  <= '0;
         tmo_cnt_q <= '0;
         multi_q   <= 1'b0;
         none_q    <= 1'b0;
         tmo_err_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         rr_ptr_q  <= rr_ptr_d;
         tmo_cnt_q <= tmo_cnt_d;
         multi_q   <= multi_d;
         none_q    <= none_d;
         tmo_err_q <= tmo_err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign gnt         = gnt_q;
   assign gnt_valid   = |gnt_q;
   assign gnt_id      = gnt_id_q;
   assign busy        = (state_q != IDLE);
   assign multi_err   = multi_q;
   assign none_err    = none_q;
   assign timeout_err = tmo_err_q;
   assign err_cnt     = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_req_unique_arbiter.sv
// ---------------------------------------------------------------------------
// tb_req_unique_arbiter : scoreboard bench with a cycle-level reference model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_req_unique_arbiter;

   localparam int N       = 4;
   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 8;
   localparam int ERR_MAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst_n;
   logic             arb_en;
   logic [N-1:0]     req;
   logic [1:0]       mode;
   logic             done;
   logic [N-1:0]     gnt;
   logic             gnt_valid;
   logic [1:0]       gnt_id;
   logic             busy;
   logic             multi_err;
   logic             none_err;
   logic             timeout_err;
   logic [CNT_W-1:0] err_cnt;

   typedef struct packed {
      logic [N-1:0]     gnt;
      logic             vld;
      logic [1:0]       id;
      logic             busy;
      logic             me;
      logic             ne;
      logic             te;
      logic [CNT_W-1:0] ec;
   } snap_t;

   snap_t exp_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   req_unique_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .arb_en      (arb_en),
      .req         (req),
      .mode        (mode),
      .done        (done),
      .gnt         (gnt),
      .gnt_valid   (gnt_valid),
      .gnt_id      (gnt_id),
      .busy        (busy),
      .multi_err   (multi_err),
      .none_err    (none_err),
      .timeout_err (timeout_err),
      .err_cnt     (err_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: owner index, grant start cycle and a cool-down flag
   int m_owner = -1;
   int m_start = 0;
   bit m_cool  = 1'b0;
   int m_ptr   = 0;
   int m_err   = 0;
   int m_cyc   = 0;

   always @(posedge clk) begin
      snap_t e;
      int    n, low, rr, win;
      e = '0;
      m_cyc++;
      win = -1;
      if (!rst_n) begin
         m_owner = -1;
         m_cool  = 1'b0;
         m_ptr   = 0;
         m_err   = 0;
      end else if (m_owner >= 0) begin
         if (done) begin
            m_owner = -1;
            m_cool  = 1'b1;
         end else if (m_cyc - m_start == TIMEOUT) begin
            m_owner = -1;
            m_cool  = 1'b1;
            e.te    = 1'b1;
         end
      end else if (m_cool) begin
         m_cool = 1'b0;
      end else if (arb_en) begin
         n   = $countones(req);
         low = -1;
         for (int i = N - 1; i >= 0; i--) if (req[i]) low = i;
         rr = -1;
         for (int k = N - 1; k >= 0; k--) if (req[(m_ptr + k) % N]) rr = (m_ptr + k) % N;
         case (mode)
            2'b00: win = low;
            2'b01: begin
               win = rr;
               if (win >= 0) m_ptr = (win + 1) % N;
            end
            2'b10: begin
               if (n == 1) win = low;
               e.me = (n > 1);
               e.ne = (n == 0);
            end
            default: begin
               if (n == 1) win = low;
               e.me = (n > 1);
            end
         endcase
         if (win >= 0) begin
            m_owner = win;
            m_start = m_cyc;
         end
      end
      if ((e.me || e.ne || e.te) && m_err < ERR_MAX) m_err++;
      if (m_owner >= 0) begin
         e.gnt[m_owner] = 1'b1;
         e.vld          = 1'b1;
         e.id           = 2'(m_owner);
      end
      e.busy = (m_owner >= 0) || m_cool;
      e.ec   = CNT_W'(m_err);
      exp_q.push_back(e);
   end

   // Monitor: one snapshot per cycle, sampled on the falling edge
   always @(negedge clk) begin
      snap_t a, e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = '{gnt, gnt_valid, gnt_id, busy, multi_err, none_err, timeout_err, err_cnt};
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL outputs @%0t: got gnt=%b vld=%b id=%0d busy=%b me=%b ne=%b te=%b ec=%0d, want gnt=%b vld=%b id=%0d busy=%b me=%b ne=%b te=%b ec=%0d",
                     $time, a.gnt, a.vld, a.id, a.busy, a.me, a.ne, a.te, a.ec,
                     e.gnt, e.vld, e.id, e.busy, e.me, e.ne, e.te, e.ec);
         end
      end
   end

   task automatic step(input bit r, input bit a, input logic [N-1:0] q,
                       input logic [1:0] m, input bit d);
      @(negedge clk);
      rst_n  = r;
      arb_en = a;
      req    = q;
      mode   = m;
      done   = d;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(1, 0, '0, 2'b00, 0);
   endtask

   initial begin
      logic [N-1:0] rq;
      rst_n  = 1'b0;
      arb_en = 1'b0;
      req    = '0;
      mode   = 2'b00;
      done   = 1'b0;
      repeat (3) step(0, 0, '0, 2'b00, 0);

      // Priority grant, release, cool-down
      step(1, 1, 4'b1010, 2'b00, 0);
      step(1, 0, 4'b1010, 2'b00, 0);
      step(1, 0, 4'b1010, 2'b00, 1);
      idle(3);

      // Round-robin fairness across all four, pointer wraps
      for (int g = 0; g < 5; g++) begin
         step(1, 1, 4'b1111, 2'b01, 0);
         step(1, 0, 4'b1111, 2'b01, 0);
         step(1, 0, 4'b1111, 2'b01, 1);
         step(1, 0, 4'b1111, 2'b01, 0);
      end

      // Unique: overlap, no-match, then a clean single request
      step(1, 1, 4'b0110, 2'b10, 0);
      step(1, 1, 4'b0000, 2'b10, 0);
      step(1, 1, 4'b0100, 2'b10, 0);
      step(1, 0, 4'b0000, 2'b10, 1);
      idle(2);

      // Unique0: silent no-match, then overlap
      step(1, 1, 4'b0000, 2'b11, 0);
      step(1, 1, 4'b0011, 2'b11, 0);
      idle(2);

      // Forced release after the full hold window
      step(1, 1, 4'b0100, 2'b00, 0);
      idle(TIMEOUT + 3);
      // Done on the last permitted cycle is a normal release
      step(1, 1, 4'b0100, 2'b00, 0);
      idle(TIMEOUT - 1);
      step(1, 0, 4'b0000, 2'b00, 1);
      idle(3);

      // Reset while requester 3 holds the grant, then RR restarts at 0
      step(1, 1, 4'b1000, 2'b00, 0);
      step(1, 0, 4'b0000, 2'b00, 0);
      step(0, 0, 4'b0000, 2'b00, 0);
      step(1, 1, 4'b1111, 2'b01, 0);
      step(1, 0, 4'b1111, 2'b01, 1);
      idle(2);

      // Error counter saturation via repeated no-match evaluations
      for (int i = 0; i < ERR_MAX + 10; i++) step(1, 1, 4'b0000, 2'b10, 0);
      step(1, 1, 4'b0001, 2'b00, 0);
      idle(TIMEOUT + 3);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 3))
            0:       rq = '0;
            1:       rq = N'(1) << $urandom_range(0, N - 1);
            default: rq = N'($urandom);
         endcase
         step(($urandom_range(0, 199) != 0), $urandom_range(0, 1), rq,
              2'($urandom_range(0, 3)), ($urandom_range(0, 11) == 0));
      end

      idle(2);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
